bvh_leaf_loader: RTL



---
 rtl/bvh_leaf_loader.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/bvh_leaf_loader.sv
// Writer side of the BVH leaf table: byte stream in, 232-bit leaf records out.
// Optional trailing XOR checksum byte: define BVH_LEAF_LOADER_CHECKSUM_EN.
module bvh_leaf_loader #(
   parameter int LEAF_ADDR_WIDTH = 10
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       start,
   input  logic [7:0]                 in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic                       wr_en,
   output logic [LEAF_ADDR_WIDTH-1:0] wr_addr,
   output logic [231:0]               wr_data,
   output logic [LEAF_ADDR_WIDTH:0]   leaf_count,
   output logic                       busy,
   output logic                       done,
   output logic                       error
);

   localparam int RECORD_BYTES = 29;
   localparam int MAX_LEAVES   = 2**LEAF_ADDR_WIDTH;
   localparam logic [16:0] MAXV  = 17'(MAX_LEAVES);
   localparam logic [4:0]  LASTB = 5'(RECORD_BYTES - 1);

   typedef enum logic [2:0] {
      IDLE,
      HDR_HI,
      HDR_LO,
      PAYLOAD,
`ifdef BVH_LEAF_LOADER_CHECKSUM_EN
      CHECK,
`endif
      DONE,
      ERROR
   } state_t;

   state_t         state;
   logic [7:0]     n_hi;
   logic [16:0]    n_total;
   logic [4:0]     bcnt;
   logic [223:0]   acc;
`ifdef BVH_LEAF_LOADER_CHECKSUM_EN
   logic [7:0]     csum;
`endif

   logic           xfer;
   logic [16:0]    hdr;
   logic           last_rec;

   assign xfer     = in_valid & in_ready;
   assign hdr      = {1'b0, n_hi, in_data};
   // leaf_count doubles as the record ordinal of the record being assembled
   assign last_rec = (17'(leaf_count) + 17'd1) == n_total;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= IDLE;
         in_ready   <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         leaf_count <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         n_hi       <= '0;
         n_total    <= '0;
         bcnt       <= '0;
         acc        <= '0;
`ifdef BVH_LEAF_LOADER_CHECKSUM_EN
         csum       <= '0;
`endif
      end else begin
         wr_en <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  done       <= 1'b0;
                  error      <= 1'b0;
                  leaf_count <= '0;
                  busy       <= 1'b1;
                  in_ready   <= 1'b1;
`ifdef BVH_LEAF_LOADER_CHECKSUM_EN
                  csum       <= '0;
`endif
                  state      <= HDR_HI;
               end
            end

            HDR_HI: begin
               if (xfer) begin
                  n_hi  <= in_data;
`ifdef BVH_LEAF_LOADER_CHECKSUM_EN
                  csum  <= csum ^ in_data;
`endif
                  state <= HDR_LO;
               end
            end

            HDR_LO: begin
               if (xfer) begin
                  n_total <= hdr;
                  bcnt    <= '0;
`ifdef BVH_LEAF_LOADER_CHECKSUM_EN
                  csum    <= csum ^ in_data;
`endif
                  if (hdr > MAXV) begin
                     error    <= 1'b1;
                     busy     <= 1'b0;
                     in_ready <= 1'b0;
                     state    <= ERROR;
                  end else if (hdr == 17'd0) begin
`ifdef BVH_LEAF_LOADER_CHECKSUM_EN
                     state    <= CHECK;
`else
                     done     <= 1'b1;
                     busy     <= 1'b0;
                     in_ready <= 1'b0;
                     state    <= DONE;
`endif
                  end else begin
                     state    <= PAYLOAD;
                  end
               end
            end

            PAYLOAD: begin
               if (xfer) begin
`ifdef BVH_LEAF_LOADER_CHECKSUM_EN
                  csum <= csum ^ in_data;
`endif
                  if (bcnt == LASTB) begin
                     wr_data    <= {acc, in_data};
                     wr_addr    <= leaf_count[LEAF_ADDR_WIDTH-1:0];
                     wr_en      <= 1'b1;
                     leaf_count <= leaf_count + 1'b1;
                     bcnt       <= '0;
                     if (last_rec) begin
`ifdef BVH_LEAF_LOADER_CHECKSUM_EN
                        state    <= CHECK;
`else
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= DONE;
`endif
                     end
                  end else begin
                     acc  <= {acc[215:0], in_data};
                     bcnt <= bcnt + 1'b1;
                  end
               end
            end

`ifdef BVH_LEAF_LOADER_CHECKSUM_EN
            CHECK: begin
               if (xfer) begin
                  busy     <= 1'b0;
                  in_ready <= 1'b0;
                  if (in_data == csum) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     error <= 1'b1;
                     state <= ERROR;
                  end
               end
            end
`endif

            DONE: begin
               state <= IDLE;
            end

            ERROR: begin
               state <= IDLE;
            end

            default: begin
               in_ready <= 1'b0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule
